// File: rtl/exec_sequencer_pkg.sv
// Shared types for the instruction sequencer: state encoding and the
// ALU unit-select codes that steer an instruction to the multiply/divide unit.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXEC       = 3'd2,
    MDU_WAIT   = 3'd3,
    MEM_REQ    = 3'd4,
    MEM_WAIT   = 3'd5,
    WB         = 3'd6,
    HALT       = 3'd7
  } state_e;

  localparam logic [3:0] MUX_MUL = 4'd5;
  localparam logic [3:0] MUX_DIV = 4'd3;

  function automatic logic is_mdu_op(input logic [3:0] sel);
    return (sel == MUX_MUL) || (sel == MUX_DIV);
  endfunction

endpackage

// File: rtl/exec_sequencer_wdog.sv
// Stall watchdog: counts enabled cycles, cleared on clr, flags expiry in the
// cycle whose edge would take the count to its all-ones value (W >= 2).
module wdog_counter #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional MDU/LSU wait,
// write-back. ALU op takes 4 cycles; every handshake may stall indefinitely up to the watchdog.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int WDOG_W   = 8,
  parameter int RETIRE_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ifu_req_valid,
  input  logic                ifu_req_ready,
  input  logic                ifu_rsp_valid,
  input  logic [31:0]         ifu_rdata,
  output logic [31:0]         instr_q,
  input  logic                is_mem,
  input  logic                is_store,
  input  logic [3:0]          alu_ctrl,
  input  logic                reg_we_dec,
  input  logic                ebreak,
  output logic                mdu_start,
  input  logic                mdu_done,
  output logic                lsu_req_valid,
  input  logic                lsu_req_ready,
  input  logic                lsu_rsp_valid,
  output logic                pc_we,
  output logic                rf_we,
  output logic                halt,
  output logic                err,
  output logic [RETIRE_W-1:0] retired,
  output logic [2:0]          state_o
);

  state_e                state_q, state_d;
  logic [31:0]           instr_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  err_q, err_d;
  logic                  wd_en, wd_clr, wd_expired;
  logic                  mdu_sel;

  assign mdu_sel = is_mdu_op(alu_ctrl);
  assign wd_en   = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                   (state_q == MDU_WAIT)  || (state_q == MEM_REQ)    ||
                   (state_q == MEM_WAIT);
  assign wd_clr  = (state_d != state_q);

  wdog_counter #(.W(WDOG_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .en      (wd_en),
    .clr     (wd_clr),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    err_d     = err_q;
    case (state_q)
      FETCH_REQ:  if (ifu_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        if (ifu_rsp_valid) begin
          state_d = EXEC;
          instr_d = ifu_rdata;
        end
      end
      EXEC: begin
        if (ebreak)       state_d = HALT;
        else if (mdu_sel) state_d = MDU_WAIT;
        else if (is_mem)  state_d = MEM_REQ;
        else              state_d = WB;
      end
      MDU_WAIT:   if (mdu_done)      state_d = WB;
      MEM_REQ:    if (lsu_req_ready) state_d = MEM_WAIT;
      MEM_WAIT:   if (lsu_rsp_valid) state_d = WB;
      WB: begin
        state_d   = FETCH_REQ;
        retired_d = retired_q + 1'b1;
      end
      HALT:       state_d = HALT;
    endcase
    // A stalled handshake loses to the watchdog even if it completes this cycle.
    if (wd_expired) begin
      state_d = HALT;
      instr_d = instr_q;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      instr_q   <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign ifu_req_valid = (state_q == FETCH_REQ);
  assign lsu_req_valid = (state_q == MEM_REQ);
  assign mdu_start     = (state_q == EXEC) && !ebreak && mdu_sel;
  assign pc_we         = (state_q == WB);
  assign rf_we         = (state_q == WB) && reg_we_dec && !is_store;
  assign halt          = (state_q == HALT);
  assign err           = err_q;
  assign retired       = retired_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a per-instruction trace model predicts
// every output each cycle; literal checks pin latencies and counters.
module tb_exec_sequencer;

  localparam int RW    = 64;
  localparam int NEVER = 100000;
  localparam logic [2:0] S_FR = 3'd0, S_FW = 3'd1, S_EX = 3'd2, S_MD = 3'd3,
                         S_MR = 3'd4, S_MW = 3'd5, S_WB = 3'd6, S_HL = 3'd7;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_MDU = 3, K_EBRK = 4;
  localparam logic [31:0] I_ADDI = 32'h0010_0093, I_LD  = 32'h0000_3083,
                          I_SD   = 32'h0011_3023, I_MUL = 32'h0231_00B3,
                          I_DIV  = 32'h0231_40B3, I_EBRK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0]   ifu_rdata, instr_q;
  logic          is_mem, is_store, reg_we_dec, ebreak;
  logic [3:0]    alu_ctrl;
  logic          mdu_start, mdu_done, lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
  logic          pc_we, rf_we, halt, err;
  logic [RW-1:0] retired;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  exec_sequencer #(.WDOG_W(8), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .instr_q(instr_q), .is_mem(is_mem), .is_store(is_store),
    .alu_ctrl(alu_ctrl), .reg_we_dec(reg_we_dec), .ebreak(ebreak),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid),
    .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .err(err),
    .retired(retired), .state_o(state_o)
  );

  // Minimal decoder: stores still raise reg_we_dec so the sequencer must mask it.
  always_comb begin
    is_mem     = (instr_q[6:0] == 7'h03) || (instr_q[6:0] == 7'h23);
    is_store   = (instr_q[6:0] == 7'h23);
    ebreak     = (instr_q == I_EBRK);
    reg_we_dec = (instr_q[6:0] != 7'h73);
    alu_ctrl   = 4'd0;
    if (instr_q[6:0] == 7'h33 && instr_q[31:25] == 7'h01)
      alu_ctrl = instr_q[14] ? 4'd3 : 4'd5;
  end

  typedef struct packed {
    logic [2:0]    st;
    logic [6:0]    fl;   // ifu_v, lsu_v, mdu_s, pc, rf, halt, err
    logic [31:0]   iq;
    logic [RW-1:0] ret;
  } obs_t;

  obs_t          exp_q[$];
  logic [31:0]   ins_q[$];
  logic [31:0]   m_iq;
  logic [RW-1:0] m_ret;
  logic          m_err;
  int            checks = 0, failures = 0;
  int            d_ireq, d_irsp, d_lreq, d_lrsp, d_mdu;
  int            ireq_n, irsp_n, lreq_n, lrsp_n, mdu_n;
  bit            ipend, lpend, mpend, stale;
  int            cyc, pc_cyc, halt_cyc, pc_n, rf_n, mdu_cnt;

  task automatic push(input logic [2:0] st, input int n, input logic mdu_s, input logic rf);
    for (int i = 0; i < n; i++) begin
      obs_t e;
      e.st  = st;
      e.fl  = {st == S_FR, st == S_MR, mdu_s, st == S_WB, rf, st == S_HL, m_err};
      e.iq  = m_iq;
      e.ret = m_ret;
      exp_q.push_back(e);
    end
  endtask

  task automatic build(input logic [31:0] ins, input int kind);
    ins_q.push_back(ins);
    push(S_FR, d_ireq + 1, 1'b0, 1'b0);
    push(S_FW, d_irsp + 1, 1'b0, 1'b0);
    m_iq = ins;
    push(S_EX, 1, kind == K_MDU, 1'b0);
    if (kind == K_EBRK) begin
      push(S_HL, 4, 1'b0, 1'b0);
      return;
    end
    if (kind == K_MDU) push(S_MD, d_mdu, 1'b0, 1'b0);
    if (kind == K_LD || kind == K_ST) begin
      push(S_MR, d_lreq + 1, 1'b0, 1'b0);
      push(S_MW, d_lrsp + 1, 1'b0, 1'b0);
    end
    push(S_WB, 1, 1'b0, kind != K_ST);
    m_ret = m_ret + 1;
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d, input int e);
    d_ireq = a; d_irsp = b; d_lreq = c; d_lrsp = d; d_mdu = e;
  endtask

  task automatic start();
    @(negedge clk);
    rst = 1'b1;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rdata = 32'hDEAD_BEEF;
    lsu_req_ready = 0; lsu_rsp_valid = 0; mdu_done = 0;
    ireq_n = 0; irsp_n = 0; lreq_n = 0; lrsp_n = 0; mdu_n = 0;
    ipend = 0; lpend = 0; mpend = 0; stale = 0;
    ins_q.delete();
    m_iq = '0; m_ret = '0; m_err = 1'b0;
    cyc = 0; pc_cyc = 0; halt_cyc = 0; pc_n = 0; rf_n = 0; mdu_cnt = 0;
  endtask

  task automatic respond();
    ifu_rsp_valid = 0; lsu_rsp_valid = 0; mdu_done = 0; ifu_rdata = 32'hDEAD_BEEF;
    if (ipend) begin
      if (irsp_n == d_irsp) begin
        ifu_rsp_valid = 1; ipend = 0;
        ifu_rdata = (ins_q.size() > 0) ? ins_q.pop_front() : 32'h0;
      end else irsp_n++;
    end
    ifu_req_ready = 0;
    if (ifu_req_valid) begin
      if (ireq_n == d_ireq) begin ifu_req_ready = 1; ipend = 1; irsp_n = 0; ireq_n = 0; end
      else ireq_n++;
    end
    if (lpend) begin
      if (lrsp_n == d_lrsp) begin lsu_rsp_valid = 1; lpend = 0; end
      else lrsp_n++;
    end
    lsu_req_ready = 0;
    if (lsu_req_valid) begin
      if (lreq_n == d_lreq) begin lsu_req_ready = 1; lpend = 1; lrsp_n = 0; lreq_n = 0; end
      else lreq_n++;
    end
    if (mpend) begin
      mdu_n++;
      if (mdu_n == d_mdu) begin mdu_done = 1; mpend = 0; end
    end
    if (mdu_start) begin mpend = 1; mdu_n = 0; end
    if (stale) begin
      ifu_rsp_valid = 1; lsu_rsp_valid = 1; mdu_done = 1; stale = 0;
    end
  endtask

  task automatic run_trace(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      rst = 1'b0;
      respond();
      n++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL trace_timeout: %0d expected cycles left after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic chk_reset();
    @(posedge clk); #1;
    lit("rst_state", {61'd0, state_o}, 64'd0);
    lit("rst_ifu_req_valid", {63'd0, ifu_req_valid}, 64'd1);
    lit("rst_retired", retired, 64'd0);
    lit("rst_instr_q", {32'd0, instr_q}, 64'd0);
    lit("rst_halt_err", {62'd0, halt, err}, 64'd0);
  endtask

  obs_t cmp_e, cmp_a;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        cmp_a.st  = state_o;
        cmp_a.fl  = {ifu_req_valid, lsu_req_valid, mdu_start, pc_we, rf_we, halt, err};
        cmp_a.iq  = instr_q;
        cmp_a.ret = retired;
        cyc++;
        if (pc_we && pc_cyc == 0) pc_cyc = cyc;
        if (halt && halt_cyc == 0) halt_cyc = cyc;
        pc_n += int'(pc_we);
        rf_n += int'(rf_we);
        mdu_cnt += int'(mdu_start);
        checks++;
        if (cmp_a !== cmp_e) begin
          failures++;
          $display("FAIL cycle %0d: got st=%0d flags=%b iq=%h ret=%0d, want st=%0d flags=%b iq=%h ret=%0d",
                   cyc, cmp_a.st, cmp_a.fl, cmp_a.iq, cmp_a.ret,
                   cmp_e.st, cmp_e.fl, cmp_e.iq, cmp_e.ret);
        end
      end
    end
  end

  initial begin
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rdata = '0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; mdu_done = 0;
    set_dly(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);

    // Single ALU instruction, zero-wait handshakes.
    set_dly(0, 0, 0, 0, 1);
    start(); build(I_ADDI, K_ALU); push(S_FR, 1, 1'b0, 1'b0);
    chk_reset(); run_trace(50);
    lit("alu_pc_we_cycle", pc_cyc, 4);
    lit("alu_rf_we_count", rf_n, 1);
    lit("alu_retired", retired, 1);

    // Load with 3-cycle request stall, response 2 cycles after accept.
    set_dly(0, 0, 3, 1, 1);
    start(); build(I_LD, K_LD); push(S_FR, 1, 1'b0, 1'b0);
    run_trace(50);
    lit("ld_pc_we_cycle", pc_cyc, 10);
    lit("ld_rf_we_count", rf_n, 1);
    lit("ld_retired", retired, 1);

    // Store: write-back without register write.
    set_dly(0, 0, 0, 0, 1);
    start(); build(I_SD, K_ST); push(S_FR, 1, 1'b0, 1'b0);
    run_trace(50);
    lit("sd_pc_we_cycle", pc_cyc, 6);
    lit("sd_rf_we_count", rf_n, 0);

    // MUL with 10-cycle MDU, then an ALU op.
    set_dly(0, 0, 0, 0, 10);
    start(); build(I_MUL, K_MDU); build(I_ADDI, K_ALU); push(S_FR, 1, 1'b0, 1'b0);
    run_trace(80);
    lit("mul_start_count", mdu_cnt, 1);
    lit("mul_pc_we_cycle", pc_cyc, 14);
    lit("mul_retired", retired, 2);

    // DIV with slow fetch and 2-cycle MDU.
    set_dly(2, 3, 0, 0, 2);
    start(); build(I_DIV, K_MDU); push(S_FR, 1, 1'b0, 1'b0);
    run_trace(50);
    lit("div_pc_we_cycle", pc_cyc, 11);

    // ALU op then ebreak: halt with retired frozen at 1.
    set_dly(0, 0, 0, 0, 1);
    start(); build(I_ADDI, K_ALU); build(I_EBRK, K_EBRK);
    run_trace(50);
    lit("ebreak_halt_cycle", halt_cyc, 8);
    lit("ebreak_retired", retired, 1);
    lit("ebreak_pc_we_count", pc_n, 1);

    // Fetch response never arrives: watchdog fires after 255 cycles in FETCH_WAIT.
    set_dly(0, NEVER, 0, 0, 1);
    start();
    push(S_FR, 1, 1'b0, 1'b0); push(S_FW, 255, 1'b0, 1'b0);
    m_err = 1'b1; push(S_HL, 4, 1'b0, 1'b0);
    run_trace(400);
    lit("wdog_halt_cycle", halt_cyc, 257);
    lit("wdog_err", {63'd0, err}, 1);
    lit("wdog_halt", {63'd0, halt}, 1);

    // Load stuck in MEM_WAIT, then reset with stale responses one cycle later.
    set_dly(0, 0, 0, NEVER, 1);
    start(); ins_q.push_back(I_LD);
    push(S_FR, 1, 1'b0, 1'b0); push(S_FW, 1, 1'b0, 1'b0);
    m_iq = I_LD; push(S_EX, 1, 1'b0, 1'b0);
    push(S_MR, 1, 1'b0, 1'b0); push(S_MW, 3, 1'b0, 1'b0);
    run_trace(50);
    lit("pre_rst_state", {61'd0, state_o}, 64'd5);
    set_dly(3, 0, 0, 0, 1);
    start(); stale = 1;
    build(I_ADDI, K_ALU); push(S_FR, 1, 1'b0, 1'b0);
    chk_reset(); run_trace(50);
    lit("post_rst_rf_we_count", rf_n, 1);
    lit("post_rst_pc_we_cycle", pc_cyc, 7);
    lit("post_rst_retired", retired, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
